// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one-cycle reads, holds the fetched word until consumed,
// follows branches and stops on the halt opcode. Define INSTR_COUNT_EN to add the retired counter.
module instr_fetch (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       imem_rd,
    output logic [9:0] imem_addr,
    input  logic [8:0] imem_data,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic       TYP,
    output logic [3:0] OP,
    output logic [3:0] operand,
    output logic [9:0] pc,
    input  logic       br_taken,
    input  logic [9:0] br_target,
`ifdef INSTR_COUNT_EN
    output logic       done,
    output logic [15:0] retired
`else
    output logic       done
`endif
);

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned INSTR_W = 9;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        HALT
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic                consume_c;
    logic                is_halt_c;

    // Halt is TYP=0 with OP=4'b1111; TYP=1 with the same OP is an ordinary instruction.
    assign is_halt_c = ~ir_q[8] && (ir_q[7:4] == 4'hF);
    assign consume_c = (state_q == HOLD) && instr_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = REQ;
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                ir_d    = imem_data;
                state_d = HOLD;
            end
            HOLD: begin
                if (instr_ready) begin
                    if (is_halt_c) begin
                        state_d = HALT;
                    end else begin
                        pc_d    = br_taken ? br_target : pc_q + ADDR_W'(1);
                        state_d = REQ;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Every output comes from a register or a state decode; no input reaches an output.
    always_comb begin
        imem_rd     = (state_q == REQ);
        imem_addr   = pc_q;
        instr_valid = (state_q == HOLD);
        done        = (state_q == HALT);
        TYP         = ir_q[8];
        OP          = ir_q[7:4];
        operand     = ir_q[3:0];
        pc          = pc_q;
    end

`ifdef INSTR_COUNT_EN
    logic [15:0] retired_q, retired_d;

    always_comb begin
        retired_d = retired_q;
        if (consume_c && (retired_q != 16'hFFFF)) retired_d = retired_q + 16'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) retired_q <= '0;
        else       retired_q <= retired_d;
    end

    assign retired = retired_q;
`else
    logic unused_consume;
    assign unused_consume = consume_c;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: transaction-level reference model, per-cycle compare, directed and random phases.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       reset, start, imem_rd, instr_valid, instr_ready, TYP, done, br_taken;
    logic [9:0] imem_addr, pc, br_target;
    logic [8:0] imem_data;
    logic [3:0] OP, operand;
`ifdef INSTR_COUNT_EN
    logic [15:0] retired;
`endif

    logic [8:0] mem [0:1023];

    int n_vec = 0;
    int n_err = 0;

    instr_fetch dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .TYP(TYP), .OP(OP), .operand(operand), .pc(pc),
        .br_taken(br_taken), .br_target(br_target),
`ifdef INSTR_COUNT_EN
        .done(done), .retired(retired)
`else
        .done(done)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous memory: data valid the cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        if (imem_rd) imem_data <= mem[imem_addr];
        else         imem_data <= 9'($urandom);
    end

    // Reference model: a fetch is "issued", "in flight", then "presented" until consumed.
    bit          m_init = 0;
    bit          m_active, m_halted;
    int          m_age;
    logic [9:0]  m_pc;
    logic [8:0]  m_instr;
    logic [15:0] m_ret;

    always @(posedge clk) begin
        if (reset) begin
            m_init = 1; m_active = 0; m_halted = 0; m_age = 0;
            m_pc = '0; m_instr = '0; m_ret = '0;
        end else if (m_init && !m_halted) begin
            if (!m_active) begin
                if (start) begin m_active = 1; m_age = 0; end
            end else if (m_age == 0) begin
                m_instr = mem[m_pc];
                m_age = 1;
            end else if (m_age == 1) begin
                m_age = 2;
            end else if (instr_ready) begin
                if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
                if (!m_instr[8] && m_instr[7:4] == 4'hF) begin
                    m_halted = 1; m_active = 0;
                end else begin
                    m_pc = br_taken ? br_target : m_pc + 10'd1;
                    m_age = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_init) begin
            chk("imem_rd", imem_rd, (m_active && m_age == 0) ? 1 : 0);
            chk("imem_addr", imem_addr, m_pc);
            chk("instr_valid", instr_valid, (m_active && m_age == 2) ? 1 : 0);
            chk("done", done, m_halted ? 1 : 0);
            chk("pc", pc, m_pc);
            if (m_active && m_age == 2) begin
                chk("TYP", TYP, m_instr[8]);
                chk("OP", OP, m_instr[7:4]);
                chk("operand", operand, m_instr[3:0]);
            end
`ifdef INSTR_COUNT_EN
            chk("retired", retired, m_ret);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; start = 0; instr_ready = 0; br_taken = 0; br_target = '0;
        for (int a = 0; a < 1024; a++) mem[a] = 9'h000;

        // First fetch latency and field decode, then a straight-line program ending in halt.
        mem[0] = 9'h101; mem[1] = 9'h012; mem[2] = 9'h123; mem[3] = 9'h0F0;
        instr_ready = 1;
        step(); step();
        reset = 0;
        chk("rst_pc", pc, 0); chk("rst_rd", imem_rd, 0); chk("rst_valid", instr_valid, 0);
        chk("rst_done", done, 0); chk("rst_ir", {TYP, OP, operand}, 0);
        start = 1; step(); start = 0;
        chk("lat_rd", imem_rd, 1); chk("lat_addr", imem_addr, 0);
        step();
        chk("lat_wait_rd", imem_rd, 0); chk("lat_wait_valid", instr_valid, 0);
        step();
        chk("lat_valid", instr_valid, 1); chk("lat_TYP", TYP, 1);
        chk("lat_OP", OP, 0); chk("lat_operand", operand, 1); chk("lat_pc", pc, 0);
        for (int i = 1; i < 4; i++) begin
            step(); step(); step();
            chk("seq_valid", instr_valid, 1); chk("seq_pc", pc, i);
        end
        step();
        chk("halt_done", done, 1); chk("halt_valid", instr_valid, 0);
        chk("halt_rd", imem_rd, 0); chk("halt_pc", pc, 3);
`ifdef INSTR_COUNT_EN
        chk("halt_retired", retired, 4);
`endif
        start = 1; step(); start = 0; step();
        chk("halt_start_done", done, 1); chk("halt_start_pc", pc, 3); chk("halt_start_rd", imem_rd, 0);

        // Stall in the presented state, branch to 0x200, then branch to 0x3FF and wrap.
        reset = 1; instr_ready = 0;
        mem[0] = 9'h055; mem[10'h200] = 9'h1A0; mem[10'h3FF] = 9'h100;
        step(); reset = 0;
        start = 1; step(); start = 0; step(); step();
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", instr_valid, 1); chk("stall_rd", imem_rd, 0);
            chk("stall_pc", pc, 0); chk("stall_operand", operand, 5);
            start = (k == 2);
            step();
        end
        start = 0;
        instr_ready = 1; br_taken = 1; br_target = 10'h200;
        step();
        chk("br_rd", imem_rd, 1); chk("br_addr", imem_addr, 10'h200);
        br_target = 10'h155;
        step(); step();
        chk("br_hold_pc", pc, 10'h200); chk("br_hold_valid", instr_valid, 1);
        br_target = 10'h3FF;
        step();
        chk("br2_addr", imem_addr, 10'h3FF);
        br_taken = 0;
        step(); step();
        chk("top_pc", pc, 10'h3FF); chk("top_TYP", TYP, 1);
        step();
        chk("wrap_rd", imem_rd, 1); chk("wrap_addr", imem_addr, 0);

        // Reset while the read is in flight abandons it; a new start re-fetches address 0.
        instr_ready = 0;
        step();
        reset = 1; step(); reset = 0;
        chk("midrst_pc", pc, 0); chk("midrst_valid", instr_valid, 0); chk("midrst_rd", imem_rd, 0);
        start = 1; step(); start = 0;
        chk("refetch_rd", imem_rd, 1); chk("refetch_addr", imem_addr, 0);

        // Random programs with random handshakes, stray branches/starts and occasional resets.
        for (int s = 0; s < 30; s++) begin
            reset = 1;
            for (int a = 0; a < 1024; a++) mem[a] = 9'($urandom);
            step(); reset = 0;
            start = 1; step(); start = 0;
            for (int c = 0; c < 150; c++) begin
                instr_ready = ($urandom_range(0, 3) != 0);
                br_taken    = ($urandom_range(0, 3) == 0);
                br_target   = 10'($urandom);
                start       = ($urandom_range(0, 9) == 0);
                reset       = ($urandom_range(0, 199) == 0);
                step();
            end
            reset = 0; start = 0;
        end

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port: start  input  1  one-cycle pulse; begins fetching from pc.
REQ-004 SHALL have port: imem_rd  output  1  instruction memory read strobe.
REQ-005 SHALL have port: imem_addr  output  10  instruction memory address; equals pc.
REQ-006 SHALL have port: imem_data  input  9  instruction word; valid the cycle after imem_rd.
REQ-007 SHALL have port: instr_valid  output  1  TYP/OP/operand hold a fetched instruction.
REQ-008 SHALL have port: instr_ready  input  1  downstream (controller/datapath) consumes the instruction.
REQ-009 SHALL have port: TYP  output  1  instruction bit 8; drives controller TYP.
REQ-010 SHALL have port: OP  output  4  instruction bits 7:4; drives controller OP.
REQ-011 SHALL have port: operand  output  4  instruction bits 3:0.
REQ-012 SHALL have port: pc  output  10  address of the presented instruction.
REQ-013 SHALL have port: br_taken  input  1  controller-qualified branch decision for the presented instruction.
REQ-014 SHALL have port: br_target  input  10  branch destination address.
REQ-015 SHALL have port: done  output  1  program halted.
REQ-016 SHALL have port: retired  output  16  retired-instruction count (present only with INSTR_COUNT_EN).

Function
REQ-017 SHALL implement FSM states IDLE, REQ, WAIT, HOLD, HALT.
REQ-018 IDLE: all strobes low; start=1 -> REQ; otherwise stay.
REQ-019 REQ: imem_rd=1, imem_addr=pc for exactly one cycle; -> WAIT unconditionally.
REQ-020 WAIT: register imem_data into instruction register; -> HOLD.
REQ-021 HOLD: instr_valid=1; TYP/OP/operand/pc stable until consumed; instr_ready=0 -> stay in HOLD.
REQ-022 HOLD with instr_ready=1 and instruction TYP=0, OP=4'b1111 (halt) -> HALT; pc unchanged; br_taken ignored.
REQ-023 HOLD with instr_ready=1, not halt: pc <= br_taken ? br_target : pc+1; -> REQ.
REQ-024 br_taken/br_target SHALL be sampled only in HOLD on the consuming cycle; ignored otherwise.
REQ-025 pc+1 SHALL wrap modulo 1024 (1023 -> 0).
REQ-026 HALT: done=1, instr_valid=0, imem_rd=0; remains until reset; start ignored.
REQ-027 start SHALL be ignored in every state except IDLE.
REQ-028 Latency: start sampled at edge N -> imem_rd high cycle N+1 -> instr_valid high from cycle N+3.
REQ-029 Throughput with instr_ready held high: one instruction per 3 cycles.
REQ-030 All outputs SHALL be registered or decoded solely from state; no combinational input-to-output path.

Reset
REQ-031 On reset: state IDLE, pc=0, instruction register=0, imem_rd=0, instr_valid=0, done=0, retired=0.
REQ-032 Reset in any state, including mid-fetch or HALT, SHALL abandon the operation and take effect on the next edge.

Configuration
REQ-033 Macro INSTR_COUNT_EN defined: retired port present; increments by 1 on every HOLD consuming cycle including halt; saturates at 16'hFFFF.
REQ-034 Macro INSTR_COUNT_EN undefined: retired port and counter absent; all other behaviour identical.

Verification
REQ-035 Reset, imem[0]=9'h101, start pulse, instr_ready=1 -> imem_rd at cycle 1, instr_valid cycle 3 with TYP=1, OP=0, operand=1, pc=0.
REQ-036 imem[0..2] non-branch, imem[3]=9'h0F0 -> pc sequence 0,1,2,3; done=1 after 4th consume; retired=4 (with macro).
REQ-037 instr_ready=0 for 5 cycles in HOLD -> outputs stable, no imem_rd; consume with br_taken=1, br_target=10'h200 -> next imem_addr=10'h200.
REQ-038 Branch target 10'h3FF non-branch there -> next pc=0 (wrap).
REQ-039 Reset asserted during WAIT -> next cycle IDLE, pc=0, instr_valid=0; start re-fetches address 0.
REQ-040 start pulses during HOLD and HALT -> no effect on pc, state or done.
